// File: rtl/uart_tx_queue.sv
// Buffered UART transmit scheduler: a DEPTH-entry byte FIFO feeding the sender
// one byte at a time, gated by the sender's tx_status start/complete handshake.
module uart_tx_queue #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int BUSY_TO = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             flush,
  input  logic             irq_en,
  input  logic             irq_ack,
  input  logic             tx_status,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             overflow,
  output logic             tx_err,
  output logic             tx_irq
);

  localparam int TO_W = $clog2(BUSY_TO) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [TO_W-1:0]  TO_ONE  = 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BUSY_TO - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [TO_W-1:0]  to_cnt;
  logic             push, pop, timeout, drained, dropped;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full && !flush;
  assign dropped = wr_en && full && !flush;
  assign pop     = (state == IDLE) && !empty && tx_status && !flush;
  assign timeout = (state == WAIT_BUSY) && tx_status && (to_cnt == TO_LAST);
  // A push landing in the completion cycle means the queue did not really drain.
  assign drained = (state == WAIT_DONE) && tx_status && (count == '0) && !push;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = SEND;
      SEND:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_status)   state_next = WAIT_DONE;
        else if (timeout) state_next = IDLE;
      end
      WAIT_DONE: if (tx_status) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_en = (state == SEND);
    busy  = (state != IDLE);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                                  to_cnt <= '0;
    else if (state == SEND)                      to_cnt <= '0;
    else if (state == WAIT_BUSY && tx_status && !timeout) to_cnt <= to_cnt + TO_ONE;
  end

  // Storage is not reset; only the pointers and count define valid contents.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)   tx_data <= '0;
    else if (pop) tx_data <= mem[rd_ptr];
  end

  // Sticky status flags; a set in the same cycle as irq_ack takes priority.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      tx_err   <= 1'b0;
      tx_irq   <= 1'b0;
    end else begin
      if (dropped)              overflow <= 1'b1;
      else if (irq_ack)         overflow <= 1'b0;
      if (timeout)              tx_err   <= 1'b1;
      else if (irq_ack)         tx_err   <= 1'b0;
      if (drained && irq_en)    tx_irq   <= 1'b1;
      else if (irq_ack)         tx_irq   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple sender model that stays busy
// 20 cycles per byte; inputs are driven and outputs sampled on falling edges.
module tb_uart_tx_queue;

  logic       sysclk, reset, wr_en, flush, irq_en, irq_ack, tx_status;
  logic [7:0] wr_data, tx_data;
  logic [3:0] count;
  logic       tx_en, full, empty, busy, overflow, tx_err, tx_irq;

  logic       auto_mode, forced_status;
  int         busy_cnt = 0;
  int         cyc = 0, last_en = -100, gap_errs = 0;
  logic [7:0] tx_log [$];
  int         n_compared = 0, n_mismatched = 0;

  uart_tx_queue #(.DEPTH(8), .PTR_W(3), .BUSY_TO(16)) dut (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .irq_en(irq_en), .irq_ack(irq_ack), .tx_status(tx_status),
    .tx_en(tx_en), .tx_data(tx_data), .count(count), .full(full),
    .empty(empty), .busy(busy), .overflow(overflow), .tx_err(tx_err),
    .tx_irq(tx_irq)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Sender model: goes busy on tx_en, idle again 20 cycles later.
  always @(posedge sysclk) begin
    if (tx_en)             busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_status = auto_mode ? (busy_cnt == 0) : forced_status;

  always @(posedge sysclk) begin
    cyc <= cyc + 1;
    if (tx_en) begin
      tx_log.push_back(tx_data);
      if (cyc - last_en < 4) gap_errs <= gap_errs + 1;
      last_en <= cyc;
    end
  end

  task automatic tick;
    @(negedge sysclk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic pulse_ack;
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick;
    n_compared++; if (count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_compared++; if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_compared++; if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    n_compared++; if (tx_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tx_en: got %b expected 0", tx_en); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_compared++; if (tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_compared++; if ({overflow, tx_err, tx_irq} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {overflow, tx_err, tx_irq}); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single;
    int n0;
    n0 = tx_log.size();
    auto_mode = 1'b1;
    irq_en = 1'b0;
    push_byte(8'h55);
    n_compared++; if (count !== 4'd1) begin n_mismatched++; $display("[TB] FAIL single_count_n1: got %0d expected 1", count); end
    n_compared++; if (tx_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_tx_en_n1: got %b expected 0", tx_en); end
    tick;
    n_compared++; if (tx_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_tx_en_n2: got %b expected 1", tx_en); end
    n_compared++; if (tx_data !== 8'h55) begin n_mismatched++; $display("[TB] FAIL single_tx_data: got %h expected 55", tx_data); end
    n_compared++; if (count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL single_count_n2: got %0d expected 0", count); end
    tick;
    n_compared++; if (tx_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_tx_en_n3: got %b expected 0", tx_en); end
    for (int i = 0; i < 100 && busy; i++) tick;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_done_timeout: got busy %b expected 0", busy); end
    n_compared++; if (tx_log.size() !== n0 + 1) begin n_mismatched++; $display("[TB] FAIL single_pulses: got %0d expected %0d", tx_log.size() - n0, 1); end
    n_compared++; if (tx_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_tx_err: got %b expected 0", tx_err); end
  endtask

  task automatic test_burst;
    int n0;
    n0 = tx_log.size();
    irq_en = 1'b1;
    auto_mode = 1'b0;
    forced_status = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    n_compared++; if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL burst_full: got %b expected 1", full); end
    n_compared++; if (count !== 4'd8) begin n_mismatched++; $display("[TB] FAIL burst_count: got %0d expected 8", count); end
    auto_mode = 1'b1;
    for (int i = 0; i < 600 && !(tx_log.size() >= n0 + 8 && !busy); i++) tick;
    n_compared++; if (tx_log.size() !== n0 + 8 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL burst_drain: got %0d pulses busy %b expected 8 pulses busy 0", tx_log.size() - n0, busy); end
    for (int i = 0; i < 8; i++) begin
      n_compared++;
      if (n0 + i >= tx_log.size()) begin n_mismatched++; $display("[TB] FAIL burst_byte%0d: got none expected %h", i, 8'(i + 1)); end
      else if (tx_log[n0 + i] !== 8'(i + 1)) begin n_mismatched++; $display("[TB] FAIL burst_byte%0d: got %h expected %h", i, tx_log[n0 + i], 8'(i + 1)); end
    end
    n_compared++; if (tx_irq !== 1'b1) begin n_mismatched++; $display("[TB] FAIL burst_irq: got %b expected 1", tx_irq); end
    pulse_ack;
    n_compared++; if (tx_irq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL burst_irq_ack: got %b expected 0", tx_irq); end
    irq_en = 1'b0;
  endtask

  task automatic test_overflow;
    int n0;
    auto_mode = 1'b0;
    forced_status = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    push_byte(8'hAA);
    n_compared++; if (overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    n_compared++; if (count !== 4'd8) begin n_mismatched++; $display("[TB] FAIL ovf_count: got %0d expected 8", count); end
    pulse_ack;
    n_compared++; if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_ack: got %b expected 0", overflow); end
    n0 = tx_log.size();
    auto_mode = 1'b1;
    for (int i = 0; i < 600 && !(tx_log.size() >= n0 + 8 && !busy); i++) tick;
    repeat (5) tick;
    n_compared++; if (tx_log.size() !== n0 + 8) begin n_mismatched++; $display("[TB] FAIL ovf_pulses: got %0d expected 8", tx_log.size() - n0); end
    for (int i = 0; i < 8; i++) begin
      n_compared++;
      if (n0 + i >= tx_log.size()) begin n_mismatched++; $display("[TB] FAIL ovf_byte%0d: got none expected %h", i, 8'hA0 + 8'(i)); end
      else if (tx_log[n0 + i] !== 8'hA0 + 8'(i)) begin n_mismatched++; $display("[TB] FAIL ovf_byte%0d: got %h expected %h", i, tx_log[n0 + i], 8'hA0 + 8'(i)); end
    end
  endtask

  task automatic test_timeout;
    auto_mode = 1'b0;
    forced_status = 1'b1;
    irq_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    tick;
    wr_data = 8'h4D;
    n_compared++; if (count !== 4'd1) begin n_mismatched++; $display("[TB] FAIL to_count_n1: got %0d expected 1", count); end
    tick;
    wr_en = 1'b0;
    n_compared++; if (tx_en !== 1'b1 || tx_data !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL to_first_issue: got tx_en %b data %h expected 1 3c", tx_en, tx_data); end
    repeat (16) tick;
    n_compared++; if (tx_err !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL to_early: got err %b busy %b expected 0 1", tx_err, busy); end
    tick;
    n_compared++; if (tx_err !== 1'b1 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_expire: got err %b busy %b expected 1 0", tx_err, busy); end
    n_compared++; if (tx_irq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_no_irq: got %b expected 0", tx_irq); end
    tick;
    n_compared++; if (tx_en !== 1'b1 || tx_data !== 8'h4D) begin n_mismatched++; $display("[TB] FAIL to_next_issue: got tx_en %b data %h expected 1 4d", tx_en, tx_data); end
    auto_mode = 1'b1;
    tick;
    for (int i = 0; i < 100 && busy; i++) tick;
    n_compared++; if (busy !== 1'b0 || tx_irq !== 1'b1) begin n_mismatched++; $display("[TB] FAIL to_second_done: got busy %b irq %b expected 0 1", busy, tx_irq); end
    pulse_ack;
    n_compared++; if (tx_err !== 1'b0 || tx_irq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_ack: got err %b irq %b expected 0 0", tx_err, tx_irq); end
    irq_en = 1'b0;
  endtask

  task automatic test_push_pop_flush;
    int n0;
    auto_mode = 1'b0;
    forced_status = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    n0 = tx_log.size();
    forced_status = 1'b1;
    push_byte(8'h44);
    forced_status = 1'b0;
    n_compared++; if (count !== 4'd3) begin n_mismatched++; $display("[TB] FAIL pp_count: got %0d expected 3", count); end
    n_compared++; if (tx_en !== 1'b1 || tx_data !== 8'h11) begin n_mismatched++; $display("[TB] FAIL pp_issue: got tx_en %b data %h expected 1 11", tx_en, tx_data); end
    repeat (2) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_compared++; if (count !== 4'd0 || empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_count: got %0d empty %b expected 0 1", count, empty); end
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_inflight: got busy %b expected 1", busy); end
    forced_status = 1'b1;
    tick;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_complete: got busy %b expected 0", busy); end
    repeat (10) tick;
    n_compared++; if (tx_log.size() !== n0 + 1) begin n_mismatched++; $display("[TB] FAIL flush_no_more: got %0d pulses expected 1", tx_log.size() - n0); end
  endtask

  task automatic test_reset_mid;
    int n0;
    auto_mode = 1'b0;
    forced_status = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
    forced_status = 1'b1;
    tick;
    forced_status = 1'b0;
    repeat (2) tick;
    n_compared++; if (count !== 4'd4 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_setup: got count %0d busy %b expected 4 1", count, busy); end
    n0 = tx_log.size();
    reset = 1'b0;
    #1;
    n_compared++; if (busy !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_async: got busy %b count %0d empty %b expected 0 0 1", busy, count, empty); end
    n_compared++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rmid_outputs: got tx_en %b data %h expected 0 00", tx_en, tx_data); end
    tick;
    reset = 1'b1;
    forced_status = 1'b1;
    repeat (10) tick;
    n_compared++; if (tx_log.size() !== n0 || count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rmid_after: got %0d pulses count %0d expected 0 0", tx_log.size() - n0, count); end
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    irq_en = 1'b0;
    irq_ack = 1'b0;
    auto_mode = 1'b1;
    forced_status = 1'b1;
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_timeout;
    test_push_pop_flush;
    test_reset_mid;
    n_compared++; if (gap_errs !== 0) begin n_mismatched++; $display("[TB] FAIL tx_en_spacing: got %0d violations expected 0", gap_errs); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
